// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, 1/2-byte instruction assembler, one-entry output slot.
// Optional fetch-address bound check: define FETCH_BOUND_CHK_EN.
module fetch_stage #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [ADDR_W-1:0] DATA_BASE = ADDR_W'(128)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_opc,
    output logic [DATA_W-1:0] out_operand,
    output logic              out_long,
    output logic [ADDR_W-1:0] out_pc,
    output logic              fetch_fault
);

`ifdef FETCH_BOUND_CHK_EN
    localparam bit BOUND_CHK = 1'b1;
`else
    localparam bit BOUND_CHK = 1'b0;
`endif

    typedef enum logic {B0, B1} state_t;

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] pc_q, pc_n, pc_inc;
    logic [ADDR_W-1:0] part_pc_q, part_pc_n;
    logic [DATA_W-1:0] part_opc_q, part_opc_n;
    logic              out_valid_n, out_long_n;
    logic [DATA_W-1:0] out_opc_n, out_operand_n;
    logic [ADDR_W-1:0] out_pc_n;
    logic              fault_q, fault_n;
    logic              slot_free, is_long, oob;

    assign i_addr      = pc_q;
    assign pc_inc      = pc_q + ADDR_W'(1);
    assign slot_free   = !out_valid || out_ready;
    assign is_long     = (i_data[DATA_W-1 -: 2] == 2'b11);
    assign oob         = BOUND_CHK && (pc_q >= DATA_BASE);
    assign fetch_fault = BOUND_CHK ? fault_q : 1'b0;

    always_comb begin
        state_n       = state_q;
        pc_n          = pc_q;
        part_pc_n     = part_pc_q;
        part_opc_n    = part_opc_q;
        out_valid_n   = out_valid;
        out_long_n    = out_long;
        out_opc_n     = out_opc;
        out_operand_n = out_operand;
        out_pc_n      = out_pc;
        fault_n       = fault_q;

        // Accepted instruction leaves the slot unless replaced below
        if (slot_free)
            out_valid_n = 1'b0;

        if (!fault_q) begin
            if (redirect_en) begin
                pc_n        = redirect_pc;
                state_n     = B0;
                out_valid_n = 1'b0;
                part_opc_n  = '0;
                part_pc_n   = '0;
            end else begin
                unique case (state_q)
                    B0: begin
                        if (is_long || slot_free) begin
                            if (oob) begin
                                fault_n = 1'b1;
                            end else if (is_long) begin
                                part_opc_n = i_data;
                                part_pc_n  = pc_q;
                                pc_n       = pc_inc;
                                state_n    = B1;
                            end else begin
                                out_opc_n     = i_data;
                                out_operand_n = '0;
                                out_long_n    = 1'b0;
                                out_pc_n      = pc_q;
                                out_valid_n   = 1'b1;
                                pc_n          = pc_inc;
                            end
                        end
                    end
                    B1: begin
                        if (slot_free) begin
                            if (oob) begin
                                fault_n = 1'b1;
                            end else begin
                                out_opc_n     = part_opc_q;
                                out_operand_n = i_data;
                                out_long_n    = 1'b1;
                                out_pc_n      = part_pc_q;
                                out_valid_n   = 1'b1;
                                pc_n          = pc_inc;
                                state_n       = B0;
                            end
                        end
                    end
                    default: state_n = B0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= B0;
            pc_q        <= RESET_PC;
            part_pc_q   <= '0;
            part_opc_q  <= '0;
            out_valid   <= 1'b0;
            out_long    <= 1'b0;
            out_opc     <= '0;
            out_operand <= '0;
            out_pc      <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_n;
            pc_q        <= pc_n;
            part_pc_q   <= part_pc_n;
            part_opc_q  <= part_opc_n;
            out_valid   <= out_valid_n;
            out_long    <= out_long_n;
            out_opc     <= out_opc_n;
            out_operand <= out_operand_n;
            out_pc      <= out_pc_n;
            fault_q     <= fault_n;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table, scoreboard stream and corner sequences.
module tb_fetch_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_addr, i_data;
    logic       redirect_en = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic       out_valid, out_ready = 1'b1;
    logic [7:0] out_opc, out_operand, out_pc;
    logic       out_long, fetch_fault;

    logic [7:0] mem [256];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] opc;
        logic [7:0] operand;
        logic       lng;
        logic [7:0] pc;
    } exp_t;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] operand;
        logic       lng;
        int         lat;
    } vec_t;

    exp_t sb[$];
    exp_t sb_e;
    bit   sb_en = 1'b0;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opc    (out_opc),
        .out_operand(out_operand),
        .out_long   (out_long),
        .out_pc     (out_pc),
        .fetch_fault(fetch_fault)
    );

    assign i_data = mem[i_addr];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_out();
        return {7'd0, out_long, out_opc, out_operand, out_pc};
    endfunction

    function automatic logic [31:0] pack_exp(logic l, logic [7:0] o,
                                             logic [7:0] d, logic [7:0] p);
        return {7'd0, l, o, d, p};
    endfunction

    always @(negedge clk) begin
        if (sb_en && !rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_extra", 32'd1, 32'd0);
            end else begin
                sb_e = sb.pop_front();
                chk("sb_instr", pack_out(),
                    pack_exp(sb_e.lng, sb_e.opc, sb_e.operand, sb_e.pc));
            end
        end
    end

    task automatic push_prog(input logic [7:0] start, input int n);
        logic [7:0] p;
        exp_t e;
        p = start;
        repeat (n) begin
            e.pc  = p;
            e.opc = mem[p];
            if (mem[p][7:6] == 2'b11) begin
                e.lng     = 1'b1;
                e.operand = mem[p + 8'd1];
                p         = p + 8'd2;
            end else begin
                e.lng     = 1'b0;
                e.operand = 8'h00;
                p         = p + 8'd1;
            end
            sb.push_back(e);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = 8'h00;
        @(posedge clk); #1;
        chk("rst_outs", {5'd0, out_valid, out_long, fetch_fault,
                         out_opc, out_operand, out_pc}, 32'd0);
        chk("rst_pc", {24'd0, i_addr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[8];
        bit   got;
        int   lat;

        vt[0] = '{8'h05, 8'h12, 8'h00, 1'b0, 1};
        vt[1] = '{8'h3F, 8'hFF, 8'h00, 1'b0, 1};
        vt[2] = '{8'h80, 8'hAA, 8'h00, 1'b0, 1};
        vt[3] = '{8'hBF, 8'h11, 8'h00, 1'b0, 1};
        vt[4] = '{8'hC0, 8'h99, 8'h99, 1'b1, 2};
        vt[5] = '{8'hC3, 8'h7A, 8'h7A, 1'b1, 2};
        vt[6] = '{8'hFF, 8'h01, 8'h01, 1'b1, 2};
        vt[7] = '{8'h7F, 8'hC3, 8'h00, 1'b0, 1};

        // Length decode and first-instruction latency
        for (int i = 0; i < 8; i++) begin
            clear_mem();
            mem[0]    = vt[i].b0;
            mem[1]    = vt[i].b1;
            out_ready = 1'b1;
            do_reset();
            got = 1'b0;
            lat = 0;
            for (int c = 1; c <= 4 && !got; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (out_valid) begin
                    got = 1'b1;
                    lat = c;
                end
            end
            chk("tbl_lat", lat, vt[i].lat);
            chk("tbl_instr", pack_out(),
                pack_exp(vt[i].lng, vt[i].b0, vt[i].operand, 8'h00));
        end

        // Long then short with no bubble
        clear_mem();
        mem[0] = 8'hC3;
        mem[1] = 8'h7A;
        mem[2] = 8'h01;
        out_ready = 1'b1;
        do_reset();
        step();
        step();
        chk("nogap_long", {out_valid, pack_out()}, {1'b1, pack_exp(1'b1, 8'hC3, 8'h7A, 8'h00)});
        step();
        chk("nogap_short", {out_valid, pack_out()}, {1'b1, pack_exp(1'b0, 8'h01, 8'h00, 8'h02)});

        // Backpressure: slot held stable, nothing lost
        clear_mem();
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
        mem[3] = 8'h44;
        out_ready = 1'b0;
        push_prog(8'h00, 4);
        sb_en = 1'b1;
        do_reset();
        step();
        for (int k = 0; k < 3; k++) begin
            chk("stall_hold", {out_valid, out_opc, out_pc, i_addr},
                {1'b1, 8'h11, 8'h00, 8'h01});
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            @(negedge clk); #1;
        end
        sb_en = 1'b0;
        chk("stall_drain", sb.size(), 0);

        // Random program under random backpressure
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        sb.delete();
        push_prog(8'h00, 40);
        sb_en = 1'b1;
        do_reset();
        for (int k = 0; k < 400 && sb.size() != 0; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            if (sb.size() == 0) sb_en = 1'b0;
            @(posedge clk); #1;
        end
        sb_en = 1'b0;
        chk("rand_drain", sb.size(), 0);

        // Redirect drops half-fetched long, then reset in B1
        clear_mem();
        mem[8'h10] = 8'hC3;
        mem[8'h11] = 8'h55;
        mem[8'h40] = 8'h07;
        out_ready  = 1'b1;
        do_reset();
        redirect_en = 1'b1;
        redirect_pc = 8'h10;
        step();
        redirect_en = 1'b0;
        chk("redir_tgt", {out_valid, i_addr}, {1'b0, 8'h10});
        step();
        chk("redir_b1", {out_valid, i_addr}, {1'b0, 8'h11});
        redirect_en = 1'b1;
        redirect_pc = 8'h40;
        step();
        redirect_en = 1'b0;
        chk("redir_flush", {out_valid, i_addr}, {1'b0, 8'h40});
        step();
        chk("redir_instr", {out_valid, pack_out()}, {1'b1, pack_exp(1'b0, 8'h07, 8'h00, 8'h40)});
        redirect_en = 1'b1;
        redirect_pc = 8'h10;
        step();
        redirect_en = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("rst_b1", {out_valid, i_addr, out_opc, out_pc}, 25'd0);
        step();
        rst = 1'b0;
        step();
        chk("rst_b1_next", {out_valid, pack_out()}, {1'b1, pack_exp(1'b0, 8'h00, 8'h00, 8'h00)});

`ifndef FETCH_BOUND_CHK_EN
        // Long opcode at top of memory wraps for its operand
        clear_mem();
        mem[8'hFF] = 8'hC0;
        mem[8'h00] = 8'h99;
        do_reset();
        redirect_en = 1'b1;
        redirect_pc = 8'hFF;
        step();
        redirect_en = 1'b0;
        step();
        chk("wrap_b1", {out_valid, i_addr}, {1'b0, 8'h00});
        step();
        chk("wrap_instr", {out_valid, pack_out()}, {1'b1, pack_exp(1'b1, 8'hC0, 8'h99, 8'hFF)});
        chk("wrap_addr", i_addr, 8'h01);
`endif

        // Crossing into the data region
        clear_mem();
        mem[8'h7F] = 8'h01;
        mem[8'h80] = 8'h02;
        do_reset();
        redirect_en = 1'b1;
        redirect_pc = 8'h7F;
        step();
        redirect_en = 1'b0;
        step();
        chk("bnd_last", {out_valid, fetch_fault, out_pc}, {1'b1, 1'b0, 8'h7F});
        step();
`ifdef FETCH_BOUND_CHK_EN
        chk("bnd_fault", {fetch_fault, out_valid, i_addr}, {1'b1, 1'b0, 8'h80});
        redirect_en = 1'b1;
        redirect_pc = 8'h10;
        step();
        redirect_en = 1'b0;
        step();
        chk("bnd_sticky", {fetch_fault, out_valid, i_addr}, {1'b1, 1'b0, 8'h80});
        rst = 1'b1;
        #1;
        chk("bnd_clear", {fetch_fault, i_addr}, {1'b0, 8'h00});
        step();
        rst = 1'b0;
`else
        chk("bnd_free", {fetch_fault, out_valid, out_opc, out_pc},
            {1'b0, 1'b1, 8'h02, 8'h80});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
